// File: rtl/lc_request_collector.sv
// lc_request_collector: assembles a transition ID then an authentication ID from host words.
// Latency: request pulses one cycle after the last word is accepted; output IDs load on that same edge.
// Backpressure: host_ready is low for 1+LOCKOUT_CYCLES cycles after each request; the host holds its word.
//
// Ports:
//   clk, rst                   single clock, synchronous active-high reset
//   host_valid/host_ready      host word handshake; host_data is most significant word first
//   host_abort                 discards the collection in progress (ignored while busy)
//   lc_transition_id           last issued transition ID (stable between requests)
//   lc_authentication_id       last issued authentication ID (stable between requests)
//   lc_transition_request_in   one-cycle request pulse
//   lc_authentication_valid    one-cycle pulse, coincident with the request pulse
//   busy                       high while issuing and during lockout
//   err_timeout                one-cycle pulse when an idle collection is discarded
//   err_parity                 one-cycle pulse on checksum mismatch (0 unless LC_REQ_PARITY_EN)
//   req_count                  saturating count of issued requests
//
// Optional feature macro: LC_REQ_PARITY_EN -- a trailing checksum word (XOR of all data words)
// must match before a request is issued.
module lc_request_collector #(
  parameter int WORD_W         = 32,
  parameter int ID_W           = 256,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LOCKOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [WORD_W-1:0] host_data,
  input  logic              host_abort,
  output logic [ID_W-1:0]   lc_transition_id,
  output logic [ID_W-1:0]   lc_authentication_id,
  output logic              lc_transition_request_in,
  output logic              lc_authentication_valid,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_parity,
  output logic [7:0]        req_count
);

  localparam int NW    = ID_W / WORD_W;
  localparam int CNT_W = $clog2(2 * NW + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LCK_W = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [2:0] S_TID   = 3'd0;
  localparam logic [2:0] S_AID   = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_LOCK  = 3'd3;
`ifdef LC_REQ_PARITY_EN
  localparam logic [2:0] S_CHECK = 3'd4;
`endif

  logic [2:0]       state;
  logic [CNT_W-1:0] word_cnt;
  logic [TMR_W-1:0] idle_tmr;
  logic [LCK_W-1:0] lock_tmr;
  logic [ID_W-1:0]  tid_stage;
  logic [ID_W-1:0]  aid_stage;
  logic [ID_W-1:0]  tid_shift;
  logic [ID_W-1:0]  aid_shift;
  logic             accept;
  logic             last_word;
  logic             timer_run;
  logic             timed_out;

`ifdef LC_REQ_PARITY_EN
  logic [WORD_W-1:0] csum;
  logic              err_parity_q;

  assign host_ready = (state == S_TID) || (state == S_AID) || (state == S_CHECK);
  // Once the first TID word lands, every later collecting state is mid-collection.
  assign timer_run  = ((state == S_TID) && (word_cnt != '0)) || (state == S_AID) ||
                      (state == S_CHECK);
  assign err_parity = err_parity_q;
`else
  assign host_ready = (state == S_TID) || (state == S_AID);
  assign timer_run  = ((state == S_TID) && (word_cnt != '0)) || (state == S_AID);
  assign err_parity = 1'b0;
`endif

  assign accept    = host_valid && host_ready && !host_abort;
  assign last_word = (word_cnt == CNT_W'(NW - 1));
  assign timed_out = timer_run && !accept && !host_abort &&
                     (idle_tmr == TMR_W'(TIMEOUT_CYCLES - 1));
  assign tid_shift = {tid_stage[ID_W-WORD_W-1:0], host_data};
  assign aid_shift = {aid_stage[ID_W-WORD_W-1:0], host_data};

  assign lc_transition_request_in = (state == S_ISSUE);
  assign lc_authentication_valid  = (state == S_ISSUE);
  assign busy                     = (state == S_ISSUE) || (state == S_LOCK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= S_TID;
      word_cnt             <= '0;
      idle_tmr             <= '0;
      lock_tmr             <= '0;
      tid_stage            <= '0;
      aid_stage            <= '0;
      lc_transition_id     <= '0;
      lc_authentication_id <= '0;
      req_count            <= '0;
      err_timeout          <= 1'b0;
`ifdef LC_REQ_PARITY_EN
      csum                 <= '0;
      err_parity_q         <= 1'b0;
`endif
    end else begin
      err_timeout <= 1'b0;
`ifdef LC_REQ_PARITY_EN
      err_parity_q <= 1'b0;
`endif
      if (host_ready && (host_abort || timed_out)) begin
        // Abort and timeout discard the partial collection alike; only timeout reports it.
        state       <= S_TID;
        word_cnt    <= '0;
        idle_tmr    <= '0;
        tid_stage   <= '0;
        aid_stage   <= '0;
        err_timeout <= timed_out;
`ifdef LC_REQ_PARITY_EN
        csum        <= '0;
`endif
      end else if (accept) begin
        idle_tmr <= '0;
        word_cnt <= word_cnt + CNT_W'(1);
`ifdef LC_REQ_PARITY_EN
        csum     <= csum ^ host_data;
`endif
        case (state)
          S_TID: begin
            tid_stage <= tid_shift;
            if (last_word) begin
              state    <= S_AID;
              word_cnt <= '0;
            end
          end
          S_AID: begin
            aid_stage <= aid_shift;
            if (last_word) begin
              word_cnt <= '0;
`ifdef LC_REQ_PARITY_EN
              state    <= S_CHECK;
`else
              // Outputs load straight from the completed staging so no partial ID is ever seen.
              state                <= S_ISSUE;
              lc_transition_id     <= tid_stage;
              lc_authentication_id <= aid_shift;
              if (req_count != 8'hFF) req_count <= req_count + 8'd1;
`endif
            end
          end
`ifdef LC_REQ_PARITY_EN
          S_CHECK: begin
            word_cnt <= '0;
            csum     <= '0;
            if (host_data == csum) begin
              state                <= S_ISSUE;
              lc_transition_id     <= tid_stage;
              lc_authentication_id <= aid_stage;
              if (req_count != 8'hFF) req_count <= req_count + 8'd1;
            end else begin
              state        <= S_TID;
              tid_stage    <= '0;
              aid_stage    <= '0;
              err_parity_q <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end else begin
        if (timer_run) idle_tmr <= idle_tmr + TMR_W'(1);
        case (state)
          S_ISSUE: begin
            state    <= S_LOCK;
            lock_tmr <= '0;
          end
          S_LOCK: begin
            if (lock_tmr == LCK_W'(LOCKOUT_CYCLES - 1)) state <= S_TID;
            else lock_tmr <= lock_tmr + LCK_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lc_request_collector.sv
`timescale 1ns/1ps
// Bench for lc_request_collector: directed table, hand-written corner sequences and random traffic,
// all compared every cycle against a word-queue reference model.
module tb_lc_request_collector;
  localparam int WORD_W = 32;
  localparam int ID_W   = 256;
  localparam int TO     = 16;
  localparam int LOCK   = 64;
  localparam int NW     = ID_W / WORD_W;
`ifdef LC_REQ_PARITY_EN
  localparam int NCOLL  = 2 * NW + 1;
`else
  localparam int NCOLL  = 2 * NW;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              host_valid = 1'b0;
  logic              host_abort = 1'b0;
  logic [WORD_W-1:0] host_data = '0;
  logic              host_ready;
  logic [ID_W-1:0]   lc_transition_id;
  logic [ID_W-1:0]   lc_authentication_id;
  logic              lc_transition_request_in;
  logic              lc_authentication_valid;
  logic              busy;
  logic              err_timeout;
  logic              err_parity;
  logic [7:0]        req_count;

  always #5 clk = ~clk;

  lc_request_collector #(
    .WORD_W(WORD_W), .ID_W(ID_W), .TIMEOUT_CYCLES(TO), .LOCKOUT_CYCLES(LOCK)
  ) dut (
    .clk(clk), .rst(rst), .host_valid(host_valid), .host_ready(host_ready),
    .host_data(host_data), .host_abort(host_abort),
    .lc_transition_id(lc_transition_id), .lc_authentication_id(lc_authentication_id),
    .lc_transition_request_in(lc_transition_request_in),
    .lc_authentication_valid(lc_authentication_valid), .busy(busy),
    .err_timeout(err_timeout), .err_parity(err_parity), .req_count(req_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [ID_W-1:0] act, input logic [ID_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the words of the current collection, idle count, and remaining blocked cycles.
  logic [WORD_W-1:0] m_words[$];
  int                m_idle;
  int                m_blocked;
  bit                m_err_to;
  bit                m_err_par;
  bit                m_accepted;
  logic [ID_W-1:0]   m_tid;
  logic [ID_W-1:0]   m_aid;
  int                m_cnt;

  task automatic model_reset();
    m_words.delete();
    m_idle = 0; m_blocked = 0; m_err_to = 0; m_err_par = 0; m_accepted = 0;
    m_tid = '0; m_aid = '0; m_cnt = 0;
  endtask

  function automatic logic [WORD_W-1:0] xor_of_words(input int n);
    logic [WORD_W-1:0] x = '0;
    for (int i = 0; i < n; i++) x ^= m_words[i];
    return x;
  endfunction

  task automatic model_finish();
`ifdef LC_REQ_PARITY_EN
    if (m_words[2*NW] != xor_of_words(2 * NW)) begin
      m_err_par = 1;
      m_words.delete();
      return;
    end
`endif
    m_tid = '0; m_aid = '0;
    for (int i = 0; i < NW; i++) begin
      m_tid = {m_tid[ID_W-WORD_W-1:0], m_words[i]};
      m_aid = {m_aid[ID_W-WORD_W-1:0], m_words[NW+i]};
    end
    m_cnt     = (m_cnt < 255) ? m_cnt + 1 : 255;
    m_blocked = LOCK + 1;
    m_words.delete();
  endtask

  task automatic model_edge(input bit v, input bit a, input logic [WORD_W-1:0] d);
    m_accepted = 0; m_err_to = 0; m_err_par = 0;
    if (m_blocked > 0) m_blocked--;
    else if (a) begin
      m_words.delete(); m_idle = 0;
    end else if (v) begin
      m_accepted = 1; m_idle = 0;
      m_words.push_back(d);
      if (m_words.size() == NCOLL) model_finish();
    end else if (m_words.size() > 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_err_to = 1; m_words.delete(); m_idle = 0;
      end
    end
  endtask

  task automatic compare_model();
    chk("host_ready", host_ready, m_blocked == 0);
    chk("busy", busy, m_blocked > 0);
    chk("request_pulse", lc_transition_request_in, m_blocked == LOCK + 1);
    chk("auth_valid_pulse", lc_authentication_valid, m_blocked == LOCK + 1);
    chk("err_timeout", err_timeout, m_err_to);
    chk("err_parity", err_parity, m_err_par);
    chk("req_count", req_count, m_cnt);
    chk("transition_id", lc_transition_id, m_tid);
    chk("authentication_id", lc_authentication_id, m_aid);
  endtask

  bit              obs_ready, obs_pulse, obs_busy, obs_err_to, obs_err_par;
  logic [ID_W-1:0] obs_tid, obs_aid;
  logic [7:0]      obs_cnt;

  // One clock: drive, sample/compare at negedge, advance model at posedge.
  task automatic cyc(input bit v, input bit a, input logic [WORD_W-1:0] d);
    host_valid = v; host_abort = a; host_data = d;
    @(negedge clk);
    compare_model();
    obs_ready = host_ready; obs_pulse = lc_transition_request_in; obs_busy = busy;
    obs_err_to = err_timeout; obs_err_par = err_parity;
    obs_tid = lc_transition_id; obs_aid = lc_authentication_id; obs_cnt = req_count;
    @(posedge clk);
    model_edge(v, a, d);
    #1;
  endtask

  task automatic apply_reset(input bit v, input logic [WORD_W-1:0] d);
    rst = 1'b1; host_valid = v; host_abort = 1'b0; host_data = d;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0; host_valid = 1'b0;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] d);
    for (int k = 0; k < 200; k++) begin
      cyc(1'b1, 1'b0, d);
      if (m_accepted) return;
    end
    chk("send_word_bound", 1'b0, 1'b1);
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 300; k++) begin
      if (m_blocked == 0) return;
      cyc(1'b0, 1'b0, '0);
    end
    chk("wait_ready_bound", 1'b0, 1'b1);
  endtask

  // Full request: TID words tb+i, AID words ab+i, plus a checksum (optionally corrupted).
  task automatic send_full(input logic [WORD_W-1:0] tb, input logic [WORD_W-1:0] ab,
                           input bit bad_ck);
    logic [WORD_W-1:0] ck = '0;
    for (int i = 0; i < NW; i++) begin
      send_word(tb + WORD_W'(i)); ck ^= tb + WORD_W'(i);
    end
    for (int i = 0; i < NW; i++) begin
      send_word(ab + WORD_W'(i)); ck ^= ab + WORD_W'(i);
    end
`ifdef LC_REQ_PARITY_EN
    send_word(ck ^ WORD_W'(bad_ck));
`else
    if (bad_ck) ck = '0;
`endif
  endtask

  function automatic logic [ID_W-1:0] build_id(input logic [WORD_W-1:0] base);
    logic [ID_W-1:0] id = '0;
    for (int i = 0; i < NW; i++) id = {id[ID_W-WORD_W-1:0], base + WORD_W'(i)};
    return id;
  endfunction

  typedef struct {
    bit                v;
    bit                a;
    logic [WORD_W-1:0] d;
    bit                exp_ready;
    bit                exp_pulse;
    bit                exp_busy;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int lows, n_to, n_req, n_par, pv;
    logic [WORD_W-1:0] ck;
    logic [WORD_W-1:0] rd;

    // Basic issue, table-driven.
    ck = '0;
    for (int i = 0; i < NW; i++) begin
      tbl.push_back('{v: 1'b1, a: 1'b0, d: 32'h0000_0001 + i, exp_ready: 1'b1, exp_pulse: 1'b0,
                      exp_busy: 1'b0});
      ck ^= 32'h0000_0001 + i;
    end
    for (int i = 0; i < NW; i++) begin
      tbl.push_back('{v: 1'b1, a: 1'b0, d: 32'hA000_0001 + i, exp_ready: 1'b1, exp_pulse: 1'b0,
                      exp_busy: 1'b0});
      ck ^= 32'hA000_0001 + i;
    end
`ifdef LC_REQ_PARITY_EN
    tbl.push_back('{v: 1'b1, a: 1'b0, d: ck, exp_ready: 1'b1, exp_pulse: 1'b0, exp_busy: 1'b0});
`endif
    tbl.push_back('{v: 1'b0, a: 1'b0, d: '0, exp_ready: 1'b0, exp_pulse: 1'b1, exp_busy: 1'b1});

    model_reset();
    apply_reset(1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    chk("reset_ready", obs_ready, 1'b1);
    chk("reset_busy", obs_busy, 1'b0);
    chk("reset_tid", obs_tid, '0);
    chk("reset_count", obs_cnt, '0);

    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl_ready[%0d]", i), obs_ready, tbl[i].exp_ready);
      chk($sformatf("tbl_pulse[%0d]", i), obs_pulse, tbl[i].exp_pulse);
      chk($sformatf("tbl_busy[%0d]", i), obs_busy, tbl[i].exp_busy);
    end
    chk("basic_tid", obs_tid, build_id(32'h0000_0001));
    chk("basic_aid", obs_aid, build_id(32'hA000_0001));
    chk("basic_count", obs_cnt, 8'd1);

    // Lockout backpressure: the held word is taken only once host_ready returns.
    lows = 0;
    for (int k = 0; k < 200; k++) begin
      cyc(1'b1, 1'b0, 32'hDEAD_BEEF);
      if (!obs_ready) lows++;
      if (m_accepted) break;
    end
    chk("lockout_low_cycles", lows, LOCK);
    for (int i = 1; i < NW; i++) send_word(32'h1000_0000 + i);
    for (int i = 0; i < NW; i++) send_word(32'h2000_0000 + i);
`ifdef LC_REQ_PARITY_EN
    send_word(xor_of_words(2 * NW));
`endif
    cyc(1'b0, 1'b0, '0);
    chk("lockout_pulse", obs_pulse, 1'b1);
    chk("lockout_tid_msw", obs_tid[ID_W-1 -: WORD_W], 32'hDEAD_BEEF);

    // Timeout: three words then silence.
    wait_ready();
    for (int i = 0; i < 3; i++) send_word(32'hBAD0_0001 + i);
    n_to = 0; n_req = 0;
    for (int k = 0; k < TO + 4; k++) begin
      cyc(1'b0, 1'b0, '0);
      n_to += int'(obs_err_to);
      n_req += int'(obs_pulse);
    end
    chk("timeout_pulses", n_to, 1);
    chk("timeout_no_request", n_req, 0);
    send_full(32'h1111_0001, 32'h2222_0001, 1'b0);
    cyc(1'b0, 1'b0, '0);
    chk("post_timeout_pulse", obs_pulse, 1'b1);
    chk("post_timeout_tid", obs_tid, build_id(32'h1111_0001));
    chk("post_timeout_aid", obs_aid, build_id(32'h2222_0001));

    // Abort colliding with word 10.
    wait_ready();
    for (int i = 0; i < NW; i++) send_word(32'h3333_0001 + i);
    send_word(32'h4444_0001);
    cyc(1'b1, 1'b1, 32'h4444_0002);
    cyc(1'b0, 1'b0, '0);
    chk("abort_no_pulse", obs_pulse, 1'b0);
    chk("abort_tid_held", obs_tid, build_id(32'h1111_0001));
    chk("abort_aid_held", obs_aid, build_id(32'h2222_0001));
    send_full(32'h5555_0001, 32'h6666_0001, 1'b0);
    cyc(1'b0, 1'b0, '0);
    chk("post_abort_tid", obs_tid, build_id(32'h5555_0001));
    chk("post_abort_aid", obs_aid, build_id(32'h6666_0001));

    // Reset during word 12.
    wait_ready();
    for (int i = 0; i < NW; i++) send_word(32'h7777_0001 + i);
    for (int i = 0; i < 3; i++) send_word(32'h8888_0001 + i);
    apply_reset(1'b1, 32'h8888_0004);
    cyc(1'b0, 1'b0, '0);
    chk("midreset_ready", obs_ready, 1'b1);
    chk("midreset_tid", obs_tid, '0);
    chk("midreset_aid", obs_aid, '0);
    chk("midreset_count", obs_cnt, '0);
    send_full(32'h9999_0001, 32'hAAAA_0001, 1'b0);
    cyc(1'b0, 1'b0, '0);
    chk("post_reset_pulse", obs_pulse, 1'b1);
    chk("post_reset_tid", obs_tid, build_id(32'h9999_0001));
    chk("post_reset_count", obs_cnt, 8'd1);

`ifdef LC_REQ_PARITY_EN
    wait_ready();
    send_full(32'hC000_0001, 32'hD000_0001, 1'b0);
    cyc(1'b0, 1'b0, '0);
    chk("parity_good_pulse", obs_pulse, 1'b1);
    chk("parity_good_count", obs_cnt, 8'd2);
    wait_ready();
    send_full(32'hE000_0001, 32'hF000_0001, 1'b1);
    n_par = 0; n_req = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, '0);
      n_par += int'(obs_err_par);
      n_req += int'(obs_pulse);
    end
    chk("parity_bad_pulses", n_par, 1);
    chk("parity_bad_no_request", n_req, 0);
    chk("parity_bad_count", obs_cnt, 8'd2);
    chk("parity_bad_tid_held", obs_tid, build_id(32'hC000_0001));
`endif

    // Random traffic with varying host activity so timeouts, aborts and stalls all occur.
    wait_ready();
    for (int s = 0; s < 15; s++) begin
      case (s % 3)
        0: pv = 90;
        1: pv = 50;
        default: pv = 5;
      endcase
      for (int k = 0; k < 200; k++) begin
        rd = $urandom();
`ifdef LC_REQ_PARITY_EN
        if (m_words.size() == 2 * NW && $urandom_range(0, 1) == 1) rd = xor_of_words(2 * NW);
`endif
        cyc($urandom_range(0, 99) < pv, $urandom_range(0, 199) == 0, rd);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1);
  end

endmodule

// File: doc/lc_request_collector.md
Name: lc_request_collector

Overview:
- Host-facing front end for the lifecycle-protection path of the MCSE control unit.
- Accepts 32-bit words from a debug/JTAG-side host and assembles a 256-bit transition ID followed by a 256-bit authentication ID.
- Presents both IDs on stable registers and issues the one-cycle lc_transition_request_in / lc_authentication_valid pulses the control unit consumes.
- Enforces an inter-word timeout, an abort path, and a post-request lockout window.

Parameters:
- WORD_W, 32, host word width; ID_W must be an integer multiple of WORD_W.
- ID_W, 256, width of each ID.
- TIMEOUT_CYCLES, 1024, idle cycles allowed between words once a collection has started.
- LOCKOUT_CYCLES, 64, cycles host_ready is held low after a request is issued.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- host_valid  in  1  host word valid
- host_ready  out  1  block can accept a word
- host_data  in  WORD_W  host word, most significant word first
- host_abort  in  1  discard the collection in progress
- lc_transition_id  out  ID_W  issued transition ID
- lc_authentication_id  out  ID_W  issued authentication ID
- lc_transition_request_in  out  1  one-cycle request pulse
- lc_authentication_valid  out  1  one-cycle pulse, coincident with the request pulse
- busy  out  1  high in ISSUE and LOCKOUT
- err_timeout  out  1  one-cycle pulse on timeout discard
- err_parity  out  1  one-cycle pulse on checksum mismatch (see Optional Feature)
- req_count  out  8  saturating count of issued requests

Behaviour:
- Reset values: all outputs 0 except host_ready. In COLLECT_TID host_ready=1, so it reads 1 in the first cycle after reset. Internal staging registers, word counter and timers are 0.
- Word accept: host_valid && host_ready && !host_abort.
- States:
  - COLLECT_TID: accept ID_W/WORD_W words and shift them into the TID staging register: stage <= {stage[ID_W-WORD_W-1:0], host_data}. After the last TID word, go to COLLECT_AID.
  - COLLECT_AID: collect the AID the same way. After its last word, go to ISSUE (or CHECK when the feature is enabled).
  - ISSUE: lasts exactly one cycle.
    - lc_transition_id and lc_authentication_id load from staging on entry.
    - Both pulses are high during this cycle only.
    - req_count increments, saturating at 255.
    - host_ready=0, busy=1.
    - Next state is LOCKOUT.
  - LOCKOUT: lasts LOCKOUT_CYCLES cycles with host_ready=0 and busy=1, then return to COLLECT_TID.
- Latency: last word accepted at edge N; pulses high in the cycle following edge N, for one cycle.
- Output registers change only on ISSUE entry and hold between requests. Partial IDs are never visible on the outputs.
- Timeout:
  - The timer runs only while at least one word of the current collection has been accepted.
  - The timer clears on every accept.
  - After TIMEOUT_CYCLES consecutive cycles with no accept: staging and word counter clear, err_timeout pulses for one cycle, next state is COLLECT_TID.
- Abort:
  - In either COLLECT state: same clear as timeout, but no error pulse.
  - Abort wins over a simultaneous host_valid; that word is dropped.
  - Abort is ignored in ISSUE and LOCKOUT.
- host_valid while host_ready=0: the word is not accepted, and the host must hold it.
- rst mid-collection or mid-lockout: full return to reset values. Output IDs and req_count clear.
- Word counter width is clog2(2*ID_W/WORD_W + 1). Counter wrap is never used; the count clears on each state change.

Optional Feature:
- Macro: LC_REQ_PARITY_EN.
- Enabled:
  - After the last AID word, state CHECK accepts one extra checksum word.
  - The checksum is the XOR of all 2*ID_W/WORD_W data words.
  - Match: go to ISSUE.
  - Mismatch: clear staging, pulse err_parity for one cycle, return to COLLECT_TID with no request issued.
  - Timeout and abort apply in CHECK.
- Disabled: no CHECK state; err_parity tied 0.

Test Plan:
- Basic issue: after reset, send TID words 0x00000001..0x00000008 and AID words 0xA0000001..0xA0000008, back to back. Expect the following and nothing more:
  - lc_transition_id = 0x00000001_00000002_..._00000008.
  - AID assembled the same way.
  - One-cycle coincident pulses in the cycle after the 16th accept.
  - req_count = 1.
  - host_ready low for 1+LOCKOUT_CYCLES cycles.
- Lockout backpressure: hold host_valid high with 0xDEADBEEF throughout LOCKOUT. Expect no accept until host_ready returns. The next request's TID MSW is 0xDEADBEEF.
- Timeout (TIMEOUT_CYCLES=16): send 3 words, then idle 16 cycles. Expect:
  - err_timeout pulses once.
  - No request pulse.
  - A fresh 16-word sequence issues correctly, and the old words do not appear in the IDs.
- Abort collision: assert host_abort together with host_valid on word 10. Expect that word dropped, staging cleared, and outputs still holding the previous request's IDs.
- Reset mid-AID: assert rst during word 12. Expect all outputs 0 and req_count=0. A subsequent full sequence issues normally.
- With LC_REQ_PARITY_EN:
  - Correct XOR checksum word: request issues.
  - Checksum XOR 0x1: err_parity pulse, no request, req_count unchanged.
